// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between MEM stage and data memory.
// Loads win the port; exact matches forward, partial overlaps stall until drained.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   input  logic             req_write,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [1:0]       req_size,
   input  logic             req_unsigned,
   output logic             req_ready,
   output logic             ld_valid,
   output logic [31:0]      ld_data,
   input  logic             drain_req,
   output logic             drain_done,
   output logic [CNT_W-1:0] sb_count,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_data_in,
   output logic [1:0]       mem_size,
   output logic             mem_unsigned,
   output logic             mem_rw,
   input  logic [31:0]      mem_rdata
);
   localparam int AW = $clog2(DEPTH);

   logic [31:0]   e_addr [DEPTH];
   logic [31:0]   e_data [DEPTH];
   logic [1:0]    e_size [DEPTH];
   logic [AW-1:0] head, tail, idx, fidx;
   logic          hit, fwd, rsv, ld_req, st_req, ld_acc, ld_port, drain_fire, st_acc, enq, full;

   function automatic logic [32:0] nbytes(input logic [1:0] s);
      return s == 2'd0 ? 33'd1 : s == 2'd1 ? 33'd2 : 33'd4;
   endfunction

   // byte ranges end at addr+n in 33 bits so the top of memory never aliases to 0
   function automatic logic overlap(input logic [31:0] a, input logic [1:0] sa,
                                    input logic [31:0] b, input logic [1:0] sb);
      return ({1'b0, a} < {1'b0, b} + nbytes(sb)) && ({1'b0, b} < {1'b0, a} + nbytes(sa));
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] d, input logic [1:0] s, input logic u);
      return s == 2'd0 ? {{24{~u & d[7]}}, d[7:0]} :
             s == 2'd1 ? {{16{~u & d[15]}}, d[15:0]} :
             s == 2'd2 ? d : 32'd0;
   endfunction

   // oldest to youngest, so the last hit is the youngest overlapping store
   always_comb begin
      hit  = 1'b0;
      fwd  = 1'b0;
      fidx = '0;
      idx  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head + AW'(k);
         if (CNT_W'(k) < sb_count && overlap(req_addr, req_size, e_addr[idx], e_size[idx])) begin
            hit  = 1'b1;
            fwd  = e_addr[idx] == req_addr && e_size[idx] == req_size;
            fidx = idx;
         end
      end
   end

   assign rsv        = req_size == 2'd3;
   assign ld_req     = req_valid & ~req_write & ~drain_req;
   assign st_req     = req_valid & req_write & ~drain_req;
   assign ld_acc     = ld_req & (rsv | ~hit | fwd);
   assign ld_port    = ld_acc & ~rsv & ~fwd;
   assign full       = sb_count == CNT_W'(DEPTH);
   assign drain_fire = (sb_count != '0) & ~ld_port;
   assign st_acc     = st_req & (~full | drain_fire);
   assign enq        = st_acc & ~rsv;
   assign req_ready  = ld_acc | st_acc;
   assign drain_done = drain_req & (sb_count == '0);

   assign mem_rw       = drain_fire;
   assign mem_addr     = drain_fire ? e_addr[head] : req_addr;
   assign mem_data_in  = drain_fire ? e_data[head] : req_wdata;
   assign mem_size     = drain_fire ? e_size[head] : req_size;
   assign mem_unsigned = drain_fire ? 1'b0 : req_unsigned;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         head     <= '0;
         tail     <= '0;
         sb_count <= '0;
         ld_valid <= 1'b0;
         ld_data  <= '0;
      end else begin
         ld_valid <= ld_acc;
         if (ld_acc) ld_data <= extend(fwd ? e_data[fidx] : mem_rdata, req_size, req_unsigned);
         if (enq) tail <= tail + 1'b1;
         if (drain_fire) head <= head + 1'b1;
         sb_count <= sb_count + CNT_W'(enq) - CNT_W'(drain_fire);
      end
   end

   always_ff @(posedge clock) begin
      if (enq) begin
         e_addr[tail] <= req_addr;
         e_data[tail] <= req_wdata;
         e_size[tail] <= req_size;
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random requests against a program-order memory model.
module tb_store_buffer;
   logic        clock = 1'b0, reset_n = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, drain_req = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [1:0]  req_size = '0;
   logic        req_ready, ld_valid, drain_done, mem_unsigned, mem_rw;
   logic [31:0] ld_data, mem_addr, mem_data_in, mem_rdata;
   logic [1:0]  mem_size;
   logic [2:0]  sb_count;

   typedef struct { logic [31:0] a, d; logic [1:0] s; } st_t;
   st_t        q[$];
   logic [7:0] mem [0:4095];
   logic [7:0] am  [0:4095];
   int         tests = 0, fails = 0;

   store_buffer #(.DEPTH(4), .CNT_W(3)) dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
      .req_ready(req_ready), .ld_valid(ld_valid), .ld_data(ld_data), .drain_req(drain_req),
      .drain_done(drain_done), .sb_count(sb_count), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_rw(mem_rw), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   function automatic int nb(input logic [1:0] s);
      return s == 2'd0 ? 1 : s == 2'd1 ? 2 : s == 2'd2 ? 4 : 0;
   endfunction

   function automatic logic [31:0] sext(input logic [31:0] v, input int n, input logic u);
      logic [31:0] hi;
      hi = n >= 4 ? 32'd0 : 32'hFFFF_FFFF << (8 * n);
      return (!u && n > 0 && n < 4 && v[8*n-1]) ? (v | hi) : v;
   endfunction

   // the data memory: little-endian, extends per size/unsigned
   always_comb begin
      logic [31:0] w;
      w = {mem[mem_addr[11:0] + 12'd3], mem[mem_addr[11:0] + 12'd2],
           mem[mem_addr[11:0] + 12'd1], mem[mem_addr[11:0]]};
      mem_rdata = mem_size == 2'd0 ? sext({24'd0, w[7:0]}, 1, mem_unsigned) :
                  mem_size == 2'd1 ? sext({16'd0, w[15:0]}, 2, mem_unsigned) : w;
   end

   function automatic logic [31:0] arch_ld(input logic [31:0] a, input logic [1:0] s, input logic u);
      logic [31:0] v;
      v = 0;
      for (int i = 0; i < nb(s); i++) v |= 32'(am[12'(a + 32'(i))]) << (8 * i);
      return sext(v, nb(s), u);
   endfunction

   function automatic bit ovl(input logic [31:0] a, input int na, input logic [31:0] b, input int nbb);
      return longint'(a) < longint'(b) + nbb && longint'(b) < longint'(a) + na;
   endfunction

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      tests++;
      assert (o === e) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, o, e);
      end
   endtask

   task automatic step(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input bit u, input bit dr);
      bit ld, st, fw, ldacc, port, dfire, stacc, rw;
      int y;
      logic [31:0] expv, wa, wd;
      logic [1:0] ws;
      @(negedge clock);
      req_valid = v; req_write = w; req_addr = a; req_wdata = d;
      req_size = s; req_unsigned = u; drain_req = dr;
      #1;
      ld = v && !w && !dr;
      st = v && w && !dr;
      y = -1;
      if (s != 2'd3)
         foreach (q[i]) if (ovl(a, nb(s), q[i].a, nb(q[i].s))) y = i;
      fw    = y >= 0 && q[y].a == a && q[y].s == s;
      ldacc = ld && (s == 2'd3 || y < 0 || fw);
      port  = ldacc && s != 2'd3 && !fw;
      dfire = q.size() != 0 && !port;
      stacc = st && (q.size() < 4 || dfire);
      chk("req_ready", 32'(req_ready), 32'(ldacc || stacc));
      chk("sb_count", 32'(sb_count), 32'(q.size()));
      chk("drain_done", 32'(drain_done), 32'(dr && q.size() == 0));
      chk("mem_rw", 32'(mem_rw), 32'(dfire));
      if (dfire) begin
         chk("drain_addr", mem_addr, q[0].a);
         chk("drain_data", mem_data_in, q[0].d);
         chk("drain_size", 32'(mem_size), 32'(q[0].s));
         chk("drain_uns", 32'(mem_unsigned), 32'd0);
      end else begin
         chk("port_addr", mem_addr, a);
      end
      expv = ldacc ? arch_ld(a, s, u) : 32'd0;
      rw = mem_rw; wa = mem_addr; wd = mem_data_in; ws = mem_size;
      @(posedge clock);
      if (rw) for (int i = 0; i < nb(ws); i++) mem[12'(wa + 32'(i))] = wd[8*i +: 8];
      if (dfire && q.size() != 0) void'(q.pop_front());
      if (stacc && s != 2'd3) begin
         q.push_back('{a: a, d: d, s: s});
         for (int i = 0; i < nb(s); i++) am[12'(a + 32'(i))] = d[8*i +: 8];
      end
      #1;
      chk("ld_valid", 32'(ld_valid), 32'(ldacc));
      if (ldacc) chk("ld_data", ld_data, expv);
   endtask

   initial begin
      logic [31:0] ra;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 8'($urandom);
         am[i]  = mem[i];
      end
      repeat (2) @(negedge clock);
      chk("rst_count", 32'(sb_count), 32'd0);
      chk("rst_ld_valid", 32'(ld_valid), 32'd0);
      chk("rst_ld_data", ld_data, 32'd0);
      chk("rst_mem_rw", 32'(mem_rw), 32'd0);
      reset_n = 1'b1;

      step(1, 1, 32'h100, 32'h1122_3344, 2'd2, 0, 0);
      step(1, 0, 32'h100, 32'h0, 2'd2, 0, 0);
      chk("fwd_word", ld_data, 32'h1122_3344);

      step(1, 1, 32'h203, 32'h0000_0080, 2'd0, 0, 0);
      step(1, 0, 32'h203, 32'h0, 2'd0, 0, 0);
      chk("lb_signed", ld_data, 32'hFFFF_FF80);
      step(1, 0, 32'h203, 32'h0, 2'd0, 1, 0);
      chk("lbu", ld_data, 32'h0000_0080);

      step(1, 1, 32'h300, 32'hAABB_CCDD, 2'd2, 0, 0);
      step(1, 0, 32'h302, 32'h0, 2'd1, 0, 0);
      step(1, 0, 32'h302, 32'h0, 2'd1, 0, 0);
      chk("lh_after_drain", ld_data, 32'hFFFF_AABB);

      step(1, 1, 32'h400, 32'h5555_5555, 2'd3, 0, 0);
      step(1, 0, 32'h400, 32'h0, 2'd3, 0, 0);
      step(1, 1, 32'h404, 32'h1234_5678, 2'd2, 0, 0);
      step(1, 1, 32'h408, 32'h9ABC_DEF0, 2'd2, 0, 1);
      step(0, 0, 32'h0, 32'h0, 2'd0, 0, 1);

      for (int n = 0; n < 400; n++) begin
         ra = 32'h100 + 32'($urandom_range(0, 23));
         step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, ra, $urandom,
              $urandom_range(0, 19) == 0 ? 2'd3 : 2'($urandom_range(0, 2)),
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
      end

      step(1, 1, 32'h500, 32'hCAFE_F00D, 2'd2, 0, 0);
      @(negedge clock);
      req_valid = 1'b0; drain_req = 1'b1; reset_n = 1'b0;
      #1;
      chk("rst_mid_count", 32'(sb_count), 32'd0);
      chk("rst_mid_mem_rw", 32'(mem_rw), 32'd0);
      q.delete();
      for (int i = 0; i < 4096; i++) am[i] = mem[i];
      @(negedge clock);
      reset_n = 1'b1;
      step(1, 0, 32'h500, 32'h0, 2'd2, 0, 0);
      step(0, 0, 32'h0, 32'h0, 2'd0, 0, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
